// File: rtl/ama_riscv_dmem_fill_ctrl.sv
// D$ line fill controller: accepts one miss, optionally writes back the dirty victim,
// reads the line with a bounded response timeout and hands the fill back to the D$.
module ama_riscv_dmem_fill_ctrl #(
    parameter int unsigned LINE_ADDR_W = 14,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    // D$ miss request
    input  logic                   miss_valid,
    output logic                   miss_ready,
    input  logic [LINE_ADDR_W-1:0] miss_addr,
    input  logic                   miss_dirty,
    input  logic [LINE_ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0]      evict_data,
    // fill return
    output logic                   fill_valid,
    input  logic                   fill_ready,
    output logic [LINE_W-1:0]      fill_data,
    output logic [LINE_ADDR_W-1:0] fill_addr,
    output logic                   fill_err,
    // memory read request
    output logic                   req_dmem_r_valid,
    input  logic                   req_dmem_r_ready,
    output logic [LINE_ADDR_W-1:0] req_dmem_r_data,
    // memory write request
    output logic                   req_dmem_w_valid,
    input  logic                   req_dmem_w_ready,
    output logic [LINE_ADDR_W-1:0] req_dmem_w_addr,
    output logic [LINE_W-1:0]      req_dmem_w_wdata,
    // memory read response
    input  logic                   rsp_dmem_valid,
    input  logic [LINE_W-1:0]      rsp_dmem_data,
    // statistics
    output logic [31:0]            cnt_fill,
    output logic [31:0]            cnt_wb
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
    // Counter reaches TIMEOUT_CYC-1 on the edge that leaves RD_WAIT.
    localparam logic [TmoW-1:0] TmoHit = TmoW'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {StIdle, StWb, StRdReq, StRdWait, StResp} state_t;

    state_t                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] miss_addr_q;
    logic [LINE_ADDR_W-1:0] evict_addr_q;
    logic [LINE_W-1:0]      evict_data_q;
    logic [LINE_W-1:0]      fill_data_q;
    logic                   fill_err_q;
    logic [TmoW-1:0]        tmo_cnt_q;
    logic [31:0]            cnt_fill_q;
    logic [31:0]            cnt_wb_q;

    logic miss_acc, wb_acc, rd_acc, fill_acc, tmo_hit;

    assign miss_acc = miss_valid && miss_ready;
    assign wb_acc   = req_dmem_w_valid && req_dmem_w_ready;
    assign rd_acc   = req_dmem_r_valid && req_dmem_r_ready;
    assign fill_acc = fill_valid && fill_ready;
    assign tmo_hit  = (tmo_cnt_q == TmoHit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (miss_valid) state_d = miss_dirty ? StWb : StRdReq;
            StWb:     if (req_dmem_w_ready) state_d = StRdReq;
            StRdReq:  if (req_dmem_r_ready) state_d = StRdWait;
            StRdWait: if (rsp_dmem_valid || tmo_hit) state_d = StResp;
            StResp:   if (fill_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Request exclusivity follows directly from the one-state-per-request decode.
    always_comb begin
        miss_ready       = 1'b0;
        req_dmem_w_valid = 1'b0;
        req_dmem_r_valid = 1'b0;
        fill_valid       = 1'b0;
        unique case (state_q)
            StIdle:   miss_ready       = 1'b1;
            StWb:     req_dmem_w_valid = 1'b1;
            StRdReq:  req_dmem_r_valid = 1'b1;
            StRdWait: ;
            StResp:   fill_valid       = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
            fill_data_q  <= '0;
            fill_err_q   <= 1'b0;
            tmo_cnt_q    <= '0;
            cnt_fill_q   <= '0;
            cnt_wb_q     <= '0;
        end else begin
            if (miss_acc) begin
                miss_addr_q  <= miss_addr;
                evict_addr_q <= evict_addr;
                evict_data_q <= evict_data;
            end
            if (wb_acc) begin
                cnt_wb_q <= cnt_wb_q + 32'd1;
            end
            if (rd_acc) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StRdWait && !rsp_dmem_valid) begin
                tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            end
            // A response in the terminal-count cycle takes priority over the timeout.
            if (state_q == StRdWait) begin
                if (rsp_dmem_valid) begin
                    fill_data_q <= rsp_dmem_data;
                    fill_err_q  <= 1'b0;
                end else if (tmo_hit) begin
                    fill_data_q <= '0;
                    fill_err_q  <= 1'b1;
                end
            end
            if (fill_acc) begin
                cnt_fill_q <= cnt_fill_q + 32'd1;
            end
        end
    end

    assign req_dmem_r_data  = miss_addr_q;
    assign req_dmem_w_addr  = evict_addr_q;
    assign req_dmem_w_wdata = evict_data_q;
    assign fill_data        = fill_data_q;
    assign fill_addr        = miss_addr_q;
    assign fill_err         = fill_err_q;
    assign cnt_fill         = cnt_fill_q;
    assign cnt_wb           = cnt_wb_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(req_dmem_r_valid && req_dmem_w_valid))
                else $error("read and write requests issued in the same cycle");
            if (rsp_dmem_valid && state_q != StRdWait) begin
                $warning("stray rsp_dmem ignored in state %s", state_q.name());
            end
        end
    end
`endif

endmodule

// File: doc/ama_riscv_dmem_fill_ctrl.md
# ama_riscv_dmem_fill_ctrl

Data-cache line fill/writeback controller: the initiator side of the data-memory request/response interface. It accepts one miss at a time from the D$ and optionally writes back a dirty victim line. It then issues the line read, captures the response and returns the fill line to the D$. Read and write requests are never issued in the same cycle, and a bounded response timeout reports a hung memory.

## Interface
- LINE_ADDR_W, 14: line (quad-word) address width; matches the memory request address width.
- LINE_W, 128: line width in bits; matches the memory data width.
- TIMEOUT_CYC, 64: maximum cycles to wait in RD_WAIT before timeout; must be ≥2.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- miss_valid  input  1  D$ miss request valid.
- miss_ready  output  1  controller can accept a miss (state IDLE).
- miss_addr  input  LINE_ADDR_W  line address to fill.
- miss_dirty  input  1  victim must be written back first.
- evict_addr  input  LINE_ADDR_W  victim line address.
- evict_data  input  LINE_W  victim line data.
- fill_valid  output  1  fill line available.
- fill_ready  input  1  D$ accepts the fill.
- fill_data  output  LINE_W  returned line.
- fill_addr  output  LINE_ADDR_W  echo of the captured miss_addr.
- fill_err  output  1  fill terminated by timeout; fill_data is 0.
- req_dmem_r  rv_if.TX  LINE_ADDR_W  read request: valid, ready, data = line address.
- req_dmem_w  rv_if_da.TX  LINE_ADDR_W/LINE_W  write request: valid, ready, addr, wdata.
- rsp_dmem  rv_if.RX  LINE_W  read response: valid, data.
- cnt_fill  output  32  count of completed fills, including errored fills; wraps.
- cnt_wb  output  32  count of accepted writebacks; wraps.

## Operation
- States are IDLE, WB, RD_REQ, RD_WAIT and RESP. Reset state is IDLE.
- **IDLE:** miss_ready = 1. On miss_valid & miss_ready:
  - register miss_addr, evict_addr, evict_data and miss_dirty;
  - go to WB if dirty, otherwise RD_REQ.
- **WB:**
  - Drive req_dmem_w.valid = 1, addr = evict_addr, wdata = evict_data.
  - Hold these stable until req_dmem_w.ready.
  - On valid & ready: cnt_wb += 1, go to RD_REQ.
- **RD_REQ:**
  - Drive req_dmem_r.valid = 1, data = miss_addr, held until req_dmem_r.ready.
  - On accept: clear the timeout counter, go to RD_WAIT.
- **RD_WAIT:**
  - On rsp_dmem.valid: capture rsp_dmem.data into fill_data, fill_err = 0, go to RESP.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_CYC-1 with no response: fill_data = 0, fill_err = 1, go to RESP.
- **RESP:**
  - fill_valid = 1; fill_data, fill_addr and fill_err are held stable.
  - On fill_ready: cnt_fill += 1, go to IDLE.
- Exclusivity: req_dmem_r.valid and req_dmem_w.valid are never both 1. This is guaranteed by the state encoding; a non-synthesis assertion checks it.
- Stray responses: rsp_dmem.valid outside RD_WAIT is ignored. A non-synthesis warning is logged.
- Ready while valid is low has no effect.
- Read-after-writeback to the same line address needs no special handling. The memory commits the write at the accept edge, and the read is issued no earlier than the next cycle.

## Timing
- Reset values:
  - miss_ready = 1 (IDLE);
  - fill_valid, fill_err, req_dmem_r.valid, req_dmem_w.valid = 0;
  - fill_data, fill_addr, request addr/data fields = 0;
  - cnt_fill, cnt_wb = 0; timeout counter = 0.
- Reset mid-operation aborts the transaction immediately (async). Any outstanding memory response after reset is ignored.
- Memory ready is registered and rises one cycle after reset release. The controller may assert valid earlier and must wait.
- Clean miss with memory ready (miss accept in cycle 0):
  - cycle 1: req_dmem_r.valid;
  - cycle 2: rsp_dmem.valid;
  - cycle 3: fill_valid.
- Dirty miss: one extra cycle (WB in cycle 1, read request in cycle 2, fill_valid in cycle 4).
- Each backpressure cycle on ready or fill_ready adds one cycle.
- A new miss can be accepted in the cycle after the fill handshake (IDLE re-entered).
- Timeout: with no rsp_dmem.valid, fill_valid with fill_err = 1 rises TIMEOUT_CYC cycles after the read accept.
- rsp_dmem.valid arriving in the same cycle as the timeout terminal count wins: the data is captured and fill_err = 0.

## Test plan
- **Clean miss:** preload mem[0x10] = 0x0123…CDEF; miss_addr = 0x10, dirty = 0, fill_ready = 1 → fill_valid 3 cycles after the accept, fill_data = 0x0123…CDEF, fill_addr = 0x10, cnt_fill = 1, cnt_wb = 0.
- **Dirty miss, same line:** evict_addr = 0x10, evict_data = 0xA5A5…, miss_addr = 0x10 → write accepted in cycle 1, read in cycle 2, fill_data = 0xA5A5… in cycle 4, cnt_wb = 1; the two valids are never high in the same cycle.
- **Backpressure:**
  - hold req_dmem_w.ready = 0 for 3 cycles → addr/wdata stay stable, fill delayed by 3;
  - hold fill_ready = 0 for 5 cycles → fill_valid and fill_data stable, miss_ready = 0 throughout.
- **Timeout:** responder never returns a response, TIMEOUT_CYC = 8 → fill_valid with fill_err = 1 and fill_data = 0 exactly 8 cycles after the read accept; cnt_fill increments; the next miss completes normally.
- **Reset mid-transaction:** assert rst while in RD_WAIT, then deliver a late rsp_dmem.valid after release → all outputs at reset values, the stray response is ignored, and no fill_valid occurs.
- **Back-to-back:** 100 random misses (50% dirty) against a reference memory model → every fill matches the model, cnt_fill = 100, cnt_wb equals the number of dirty misses.
